// File: rtl/mc32_fetch_alu_bus.sv
// ============================================================================
// mc32_fetch_alu_bus
//
// Front-end datapath slice of the MaxiCore32 CPU. It holds three independent
// functions:
//   * a combinational 32-bit ALU with carry/zero/negative/overflow flags;
//   * a combinational big-endian bus interface that maps CPU BYTE/WORD/LONG
//     cycles onto a 32-bit strobed bus and flags misaligned accesses;
//   * a registered fetch stage that latches instructions from the bus read
//     path, inserts one memory-access cycle after a load/store and detects
//     HALT.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> ALU op 4'hF is an unsigned 32x32 multiply (low word result,
//                carry set when the high word is nonzero, overflow 0).
//   undefined -> ALU op 4'hF returns 0 with every flag clear except zero.
//
// Parameters
//   RESET_INSTR           instruction presented after reset (NOP by default)
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   alu_op                ALU operation select
//   alu_reg2 / alu_reg3   ALU operands A / B
//   alu_carry_in          carry (add) or borrow (subtract) input
//   alu_result            ALU result
//   alu_*_out             carry, zero, negative, overflow flags
//   cpu_address           CPU byte address
//   cpu_cycle_width       0 BYTE, 1 WORD, 2/3 LONG
//   cpu_data_out          CPU write data, right-justified
//   cpu_read, cpu_write   CPU cycle requests
//   cpu_data_in           read data to the CPU, right-justified, zero-extended
//   address               bus long-word address (cpu_address[31:2])
//   data_in / data_out    bus read data / bus write data on byte lanes
//   data_strobes          byte-lane enables, bit 3 = bits [31:24]
//   read, write           bus cycle controls
//   bus_error             misaligned access indication
//   outbound_instruction  instruction latched for the next pipeline stage
//   block_fetch           high during the inserted memory-access cycle
//   halting               sticky HALT indication, cleared only by reset
// ============================================================================
module mc32_fetch_alu_bus #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    // ALU
    input  logic [3:0]  alu_op,
    input  logic [31:0] alu_reg2,
    input  logic [31:0] alu_reg3,
    input  logic        alu_carry_in,
    output logic [31:0] alu_result,
    output logic        alu_carry_out,
    output logic        alu_zero_out,
    output logic        alu_neg_out,
    output logic        alu_over_out,
    // CPU side of the bus interface
    input  logic [31:0] cpu_address,
    input  logic [1:0]  cpu_cycle_width,
    input  logic [31:0] cpu_data_out,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_data_in,
    // External bus
    output logic [29:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  data_strobes,
    output logic        read,
    output logic        write,
    output logic        bus_error,
    // Fetch stage
    output logic [31:0] outbound_instruction,
    output logic        block_fetch,
    output logic        halting
);

    // ------------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------------
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_LSL  = 4'h8;
    localparam logic [3:0] OP_LSR  = 4'h9;
    localparam logic [3:0] OP_ASR  = 4'hA;
    localparam logic [3:0] OP_COPY = 4'hB;
    localparam logic [3:0] OP_NEG  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hD;
    localparam logic [3:0] OP_DEC  = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    // All add/subtract style ops share one 33-bit adder. Each op only picks
    // the operands, the carry/borrow input and the direction.
    logic [31:0] arith_x;
    logic [31:0] arith_y;
    logic        arith_cin;
    logic        arith_sub;
    logic [32:0] arith_sum;
    logic        arith_ovf;

    always_comb begin
        arith_x   = alu_reg2;
        arith_y   = alu_reg3;
        arith_cin = 1'b0;
        arith_sub = 1'b0;
        case (alu_op)
            OP_ADDC: arith_cin = alu_carry_in;
            OP_SUB:  arith_sub = 1'b1;
            OP_SUBC: begin
                arith_sub = 1'b1;
                arith_cin = alu_carry_in;
            end
            OP_NEG: begin
                arith_x   = 32'h0000_0000;
                arith_sub = 1'b1;
            end
            OP_INC:  arith_y = 32'h0000_0001;
            OP_DEC: begin
                arith_y   = 32'h0000_0001;
                arith_sub = 1'b1;
            end
            default: ;
        endcase
    end

    // Bit 32 is the carry for additions; for subtractions the 33-bit result
    // wraps negative, so bit 32 doubles as the borrow.
    assign arith_sum = arith_sub
        ? ({1'b0, arith_x} - {1'b0, arith_y} - {32'h0, arith_cin})
        : ({1'b0, arith_x} + {1'b0, arith_y} + {32'h0, arith_cin});

    // Signed overflow: add overflows when operands agree in sign and the
    // result does not; subtract when operands differ and the result sign
    // differs from the minuend.
    assign arith_ovf = arith_sub
        ? ((arith_x[31] != arith_y[31]) && (arith_sum[31] != arith_x[31]))
        : ((arith_x[31] == arith_y[31]) && (arith_sum[31] != arith_x[31]));

`ifdef ALU_MUL_EN
    logic [63:0] mul_product;
    assign mul_product = {32'h0, alu_reg2} * {32'h0, alu_reg3};
`endif

    always_comb begin
        alu_result    = 32'h0000_0000;
        alu_carry_out = 1'b0;
        alu_over_out  = 1'b0;
        case (alu_op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_NEG, OP_INC, OP_DEC: begin
                alu_result    = arith_sum[31:0];
                alu_carry_out = arith_sum[32];
                alu_over_out  = arith_ovf;
            end
            OP_AND:  alu_result = alu_reg2 & alu_reg3;
            OP_OR:   alu_result = alu_reg2 | alu_reg3;
            OP_XOR:  alu_result = alu_reg2 ^ alu_reg3;
            OP_NOT:  alu_result = ~alu_reg3;
            OP_COPY: alu_result = alu_reg3;
            OP_LSL: begin
                alu_result    = {alu_reg2[30:0], 1'b0};
                alu_carry_out = alu_reg2[31];
            end
            OP_LSR: begin
                alu_result    = {1'b0, alu_reg2[31:1]};
                alu_carry_out = alu_reg2[0];
            end
            OP_ASR: begin
                alu_result    = {alu_reg2[31], alu_reg2[31:1]};
                alu_carry_out = alu_reg2[0];
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                alu_result    = mul_product[31:0];
                alu_carry_out = |mul_product[63:32];
`else
                alu_result    = 32'h0000_0000;
`endif
            end
            default: ;
        endcase
    end

    assign alu_zero_out = (alu_result == 32'h0000_0000);
    assign alu_neg_out  = alu_result[31];

    // ------------------------------------------------------------------------
    // Bus interface (big-endian: byte offset 0 lives on lane 3, bits [31:24])
    // ------------------------------------------------------------------------
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_WORD = 2'd1;

    logic [1:0]  byte_offset;
    logic [7:0]  lane_byte [4];
    logic [3:0]  lane_select;
    logic        misaligned;
    logic        cycle_request;
    logic [31:0] read_data;

    assign byte_offset   = cpu_address[1:0];
    assign address       = cpu_address[31:2];
    assign cycle_request = cpu_read | cpu_write;

    // Per-lane views of the bus: lane gi covers bits [8*gi+7 : 8*gi].
    // Write data is replicated so the addressed lanes always carry it:
    // bytes on every lane, words on both halves, longs unchanged.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = data_in[8*gi +: 8];
            always_comb begin
                if (cpu_cycle_width == WIDTH_BYTE) begin
                    data_out[8*gi +: 8] = cpu_data_out[7:0];
                end else if (cpu_cycle_width == WIDTH_WORD) begin
                    data_out[8*gi +: 8] = cpu_data_out[8*(gi % 2) +: 8];
                end else begin
                    data_out[8*gi +: 8] = cpu_data_out[8*gi +: 8];
                end
            end
        end
    endgenerate

    always_comb begin
        lane_select = 4'b1111;
        misaligned  = 1'b0;
        read_data   = data_in;
        case (cpu_cycle_width)
            WIDTH_BYTE: begin
                lane_select = 4'b1000 >> byte_offset;
                read_data   = {24'h0, lane_byte[2'd3 - byte_offset]};
            end
            WIDTH_WORD: begin
                misaligned  = byte_offset[0];
                lane_select = byte_offset[1] ? 4'b0011 : 4'b1100;
                read_data   = byte_offset[1] ? {16'h0, data_in[15:0]}
                                             : {16'h0, data_in[31:16]};
            end
            default: begin
                // LONG, and the unused encoding 3 which behaves as LONG
                misaligned = (byte_offset != 2'b00);
            end
        endcase
    end

    // A misaligned address is reported whether or not a cycle is requested;
    // it always suppresses the bus cycle itself.
    assign bus_error    = misaligned;
    assign read         = cpu_read  & ~misaligned;
    assign write        = cpu_write & ~misaligned;
    assign data_strobes = (cycle_request && !misaligned) ? lane_select : 4'b0000;
    assign cpu_data_in  = read_data;

    // ------------------------------------------------------------------------
    // Fetch stage
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,   // latch a new instruction every edge
        ST_MEM    = 2'd1,   // one-cycle slot for a load/store data access
        ST_HALTED = 2'd2    // sticky until reset, feeds NOPs downstream
    } fetch_state_t;

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic [31:0]  instr_reg;
    logic [31:0]  instr_next;
    logic         is_load_store;
    logic         is_halt;

    // Classification is done on the word being latched, so the state
    // change lands on the same edge as the instruction itself.
    assign is_load_store = (cpu_data_in[31:28] == 4'h1);
    assign is_halt       = (cpu_data_in[31:26] == 6'h01);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            instr_reg <= RESET_INSTR;
        end else begin
            state_reg <= state_next;
            instr_reg <= instr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        case (state_reg)
            ST_FETCH: begin
                instr_next = cpu_data_in;
                if (is_halt) begin
                    state_next = ST_HALTED;
                end else if (is_load_store) begin
                    state_next = ST_MEM;
                end
            end
            ST_MEM: begin
                // Instruction held while the memory access uses the bus.
                state_next = ST_FETCH;
            end
            ST_HALTED: begin
                instr_next = 32'h0000_0000;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    assign outbound_instruction = instr_reg;
    assign block_fetch          = (state_reg == ST_MEM);
    assign halting              = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_mc32_fetch_alu_bus.sv
// ============================================================================
// tb_mc32_fetch_alu_bus
//
// Self-checking bench for mc32_fetch_alu_bus. Directed steps from the test
// plan plus randomized ALU/bus/fetch traffic, all compared against a
// behavioural reference model built from plain integer arithmetic. One line
// per transaction, one summary line at the end.
// ============================================================================
module tb_mc32_fetch_alu_bus;

    logic        clock;
    logic        reset;
    logic [3:0]  alu_op;
    logic [31:0] alu_reg2;
    logic [31:0] alu_reg3;
    logic        alu_carry_in;
    logic [31:0] alu_result;
    logic        alu_carry_out;
    logic        alu_zero_out;
    logic        alu_neg_out;
    logic        alu_over_out;
    logic [31:0] cpu_address;
    logic [1:0]  cpu_cycle_width;
    logic [31:0] cpu_data_out;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_data_in;
    logic [29:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read;
    logic        write;
    logic        bus_error;
    logic [31:0] outbound_instruction;
    logic        block_fetch;
    logic        halting;

    int vectors;
    int miscompares;
    int step_no;

    // Reference state of the fetch stage
    logic [31:0] m_instr;
    logic        m_block;
    logic        m_halt;

    mc32_fetch_alu_bus #(.RESET_INSTR(32'h0000_0000)) dut (
        .clock                (clock),
        .reset                (reset),
        .alu_op               (alu_op),
        .alu_reg2             (alu_reg2),
        .alu_reg3             (alu_reg3),
        .alu_carry_in         (alu_carry_in),
        .alu_result           (alu_result),
        .alu_carry_out        (alu_carry_out),
        .alu_zero_out         (alu_zero_out),
        .alu_neg_out          (alu_neg_out),
        .alu_over_out         (alu_over_out),
        .cpu_address          (cpu_address),
        .cpu_cycle_width      (cpu_cycle_width),
        .cpu_data_out         (cpu_data_out),
        .cpu_read             (cpu_read),
        .cpu_write            (cpu_write),
        .cpu_data_in          (cpu_data_in),
        .address              (address),
        .data_in              (data_in),
        .data_out             (data_out),
        .data_strobes         (data_strobes),
        .read                 (read),
        .write                (write),
        .bus_error            (bus_error),
        .outbound_instruction (outbound_instruction),
        .block_fetch          (block_fetch),
        .halting              (halting)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step=%0d observed=0x%08h expected=0x%08h", tag, step_no, obs, exp);
        end
    endtask

    // ALU reference: integer arithmetic on wide signed/unsigned values.
    task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, output logic [31:0] r, output logic c,
                             output logic v);
        longint ua, ub, sa, sb, us, ss;
        logic [63:0] prod;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        us = 0;
        ss = 0;
        r = 32'h0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0, 4'h1, 4'hD: begin
                if (op == 4'hD) begin ub = 1; sb = 1; end
                us = ua + ub + ((op == 4'h1) ? longint'(cin) : 0);
                ss = sa + sb + ((op == 4'h1) ? longint'(cin) : 0);
                r = us[31:0];
                c = (us > 64'sd4294967295);
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'h2, 4'h3, 4'hC, 4'hE: begin
                if (op == 4'hC) begin ua = 0; sa = 0; end
                if (op == 4'hE) begin ub = 1; sb = 1; end
                us = ua - ub - ((op == 4'h3) ? longint'(cin) : 0);
                ss = sa - sb - ((op == 4'h3) ? longint'(cin) : 0);
                r = us[31:0];
                c = (us < 0);
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = ~b;
            4'h8: begin r = a << 1; c = a[31]; end
            4'h9: begin r = a >> 1; c = a[0]; end
            4'hA: begin r = $signed(a) >>> 1; c = a[0]; end
            4'hB: r = b;
            default: begin
`ifdef ALU_MUL_EN
                prod = 64'(a) * 64'(b);
                r = prod[31:0];
                c = (prod[63:32] != 0);
`else
                prod = 64'h0;
                r = prod[31:0];
`endif
            end
        endcase
    endtask

    // Bus reference: byte offset o maps to the lane counted from the top.
    task automatic bus_model(output logic [3:0] stb, output logic [31:0] cdi,
                             output logic [31:0] dbus, output logic rd, output logic wr,
                             output logic err);
        int off;
        logic [3:0] lanes;
        off = int'(cpu_address[1:0]);
        if (cpu_cycle_width == 2'd0) begin
            err   = 1'b0;
            lanes = 4'b1000 >> off;
            cdi   = (data_in >> (8 * (3 - off))) & 32'h0000_00FF;
            dbus  = {4{cpu_data_out[7:0]}};
        end else if (cpu_cycle_width == 2'd1) begin
            err   = (off % 2) != 0;
            lanes = (off >= 2) ? 4'b0011 : 4'b1100;
            cdi   = (data_in >> ((off >= 2) ? 0 : 16)) & 32'h0000_FFFF;
            dbus  = {2{cpu_data_out[15:0]}};
        end else begin
            err   = (off != 0);
            lanes = 4'b1111;
            cdi   = data_in;
            dbus  = cpu_data_out;
        end
        rd  = cpu_read && !err;
        wr  = cpu_write && !err;
        stb = (err || !(cpu_read || cpu_write)) ? 4'b0000 : lanes;
    endtask

    // One transaction: inputs are already driven (just after a falling edge).
    task automatic step();
        logic [31:0] er, cdi, dbus;
        logic ec, ev, rd, wr, err;
        logic [3:0] stb;
        step_no++;
        #1;
        alu_model(alu_op, alu_reg2, alu_reg3, alu_carry_in, er, ec, ev);
        bus_model(stb, cdi, dbus, rd, wr, err);
        check("alu_result", alu_result, er);
        check("alu_carry", 32'(alu_carry_out), 32'(ec));
        check("alu_zero", 32'(alu_zero_out), 32'(er == 32'h0));
        check("alu_neg", 32'(alu_neg_out), 32'(er[31]));
        check("alu_over", 32'(alu_over_out), 32'(ev));
        check("address", 32'(address), 32'(cpu_address >> 2));
        check("strobes", 32'(data_strobes), 32'(stb));
        check("read", 32'(read), 32'(rd));
        check("write", 32'(write), 32'(wr));
        check("bus_error", 32'(bus_error), 32'(err));
        if (!err) begin
            check("cpu_data_in", cpu_data_in, cdi);
            check("data_out", data_out, dbus);
        end
        @(posedge clock);
        if (reset) begin
            m_instr = 32'h0;
            m_block = 1'b0;
            m_halt  = 1'b0;
        end else if (m_halt) begin
            m_instr = 32'h0;
        end else if (m_block) begin
            m_block = 1'b0;
        end else begin
            m_instr = cdi;
            m_block = (cdi[31:28] == 4'h1);
            m_halt  = (cdi[31:26] == 6'h01);
        end
        @(negedge clock);
        check("outbound_instruction", outbound_instruction, m_instr);
        check("block_fetch", 32'(block_fetch), 32'(m_block));
        check("halting", 32'(halting), 32'(m_halt));
        $display("step %0d op=%h a=%h b=%h res=%h addr=%h w=%0d stb=%b err=%b instr=%h blk=%b halt=%b",
                 step_no, alu_op, alu_reg2, alu_reg3, alu_result, cpu_address, cpu_cycle_width,
                 data_strobes, bus_error, outbound_instruction, block_fetch, halting);
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
        alu_op = op; alu_reg2 = a; alu_reg3 = b; alu_carry_in = cin;
    endtask

    task automatic set_bus(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] dout,
                           input logic [31:0] din, input logic rd, input logic wr);
        cpu_address = addr; cpu_cycle_width = w; cpu_data_out = dout;
        data_in = din; cpu_read = rd; cpu_write = wr;
    endtask

    // Aligned LONG read: cpu_data_in carries the fetched word unchanged.
    task automatic fetch_word(input logic [31:0] w);
        set_bus(32'h0000_0100, 2'd2, 32'h0, w, 1'b1, 1'b0);
        step();
    endtask

    initial begin
        logic [31:0] w;
        vectors = 0;
        miscompares = 0;
        step_no = 0;
        m_instr = 32'h0;
        m_block = 1'b0;
        m_halt  = 1'b0;
        reset = 1'b1;
        set_alu(4'h0, 32'h0, 32'h0, 1'b0);
        set_bus(32'h0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state
        check("reset_instr", outbound_instruction, 32'h0000_0000);
        check("reset_block", 32'(block_fetch), 32'h0);
        check("reset_halt", 32'(halting), 32'h0);

        // Directed ALU
        set_alu(4'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        #1;
        check("add_wrap_res", alu_result, 32'h0);
        check("add_wrap_c", 32'(alu_carry_out), 32'h1);
        check("add_wrap_z", 32'(alu_zero_out), 32'h1);
        check("add_wrap_v", 32'(alu_over_out), 32'h0);
        step();
        set_alu(4'h2, 32'h8000_0000, 32'h1, 1'b0);
        #1;
        check("sub_ovf_res", alu_result, 32'h7FFF_FFFF);
        check("sub_ovf_v", 32'(alu_over_out), 32'h1);
        step();
        set_alu(4'hF, 32'h3, 32'h5, 1'b0);
        #1;
`ifdef ALU_MUL_EN
        check("mul_res", alu_result, 32'd15);
`else
        check("opf_res", alu_result, 32'h0);
        check("opf_zero", 32'(alu_zero_out), 32'h1);
`endif
        step();

        // Directed bus
        set_bus(32'h0000_1003, 2'd0, 32'h0, 32'hAABB_CCDD, 1'b1, 1'b0);
        #1;
        check("byte_addr", 32'(address), 32'h0000_0400);
        check("byte_stb", 32'(data_strobes), 32'h1);
        check("byte_data", cpu_data_in, 32'h0000_00DD);
        check("byte_read", 32'(read), 32'h1);
        step();
        set_bus(32'h0000_2002, 2'd1, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
        #1;
        check("word_stb", 32'(data_strobes), 32'h3);
        check("word_data", 32'(data_out[15:0]), 32'h0000_1234);
        step();
        set_bus(32'h0000_2001, 2'd2, 32'h0, 32'h0, 1'b1, 1'b1);
        #1;
        check("long_err", 32'(bus_error), 32'h1);
        check("long_err_rw", 32'({read, write}), 32'h0);
        check("long_err_stb", 32'(data_strobes), 32'h0);
        step();

        // Randomized ALU and bus traffic with the fetch stage held in reset
        for (int i = 0; i < 200; i++) begin
            set_alu(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) alu_reg2 = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) alu_reg3 = 32'hFFFF_FFFF;
            set_bus($urandom, 2'($urandom_range(0, 3)), $urandom, $urandom,
                    1'($urandom), 1'($urandom));
            step();
        end

        // Fetch: load/store sequence
        reset = 1'b0;
        set_alu(4'h0, 32'h0, 32'h0, 1'b0);
        fetch_word(32'h0000_0000);
        fetch_word(32'h1000_0004);
        check("ls_block_on", 32'(block_fetch), 32'h1);
        check("ls_instr", outbound_instruction, 32'h1000_0004);
        fetch_word($urandom);
        check("ls_block_off", 32'(block_fetch), 32'h0);
        check("ls_instr_held", outbound_instruction, 32'h1000_0004);
        fetch_word(32'h0000_0000);
        check("ls_next", outbound_instruction, 32'h0000_0000);

        // Randomized fetch stream, HALT encodings excluded
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    w = $urandom;
                    if (w[31:26] == 6'h01) w[31:26] = 6'h02;
                end
                1: w = {4'h1, 28'($urandom)};
                default: w = 32'h0;
            endcase
            fetch_word(w);
        end

        // HALT: sticky while data changes, cleared by reset
        fetch_word(32'h0000_0000);
        fetch_word(32'h0000_0000);
        fetch_word(32'h0400_0000);
        check("halt_set", 32'(halting), 32'h1);
        for (int i = 0; i < 4; i++) begin
            fetch_word($urandom);
            check("halt_sticky", 32'(halting), 32'h1);
            check("halt_nop", outbound_instruction, 32'h0);
        end
        reset = 1'b1;
        fetch_word(32'h1234_5678);
        check("halt_cleared", 32'(halting), 32'h0);
        reset = 1'b0;
        fetch_word(32'h1000_0000);
        fetch_word(32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
